ctrl_sequencer: RTL and testbench

- Control unit driving the CTRL_* inputs of the 9-bit-ISA datapath: decodes opcode/fcode into control strobes and sequences run/halt.
- Owns start-up: accepts a host START request, issues a one-cycle datapath init pulse, runs until DONE or a HALT instruction, then reports completion.
- Inserts wait cycles on loads so data_mem read data settles before write-back; counts retired instructions for performance checks.

---
 rtl/ctrl_sequencer.sv | 171 +++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Control sequencer for the 9-bit-ISA datapath: decodes opcode/fcode into
// datapath strobes, owns start-up/halt, stalls loads and counts retirements.
module ctrl_sequencer #(
    parameter int LOAD_WAIT = 1,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [3:0]       opcode,
    input  logic             fcode,
    input  logic             DONE,
    output logic             DP_INIT,
    output logic             PC_HOLD,
    output logic             CTRL_branch_rel_nz,
    output logic             CTRL_branch_rel_z,
    output logic             CTRL_branch_abs,
    output logic             CTRL_reg_write_en,
    output logic             CTRL_reg_sel,
    output logic             CTRL_lut_in,
    output logic             CTRL_mem_to_reg,
    output logic             CTRL_alu_src,
    output logic             CTRL_alu_sc_in,
    output logic             CTRL_read_mem,
    output logic             CTRL_write_mem,
    output logic [2:0]       CTRL_alu_op,
    output logic             BUSY,
    output logic             FINISHED,
    output logic [CNT_W-1:0] INSTR_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_LOAD,
        S_HALTED
    } state_t;

    // LOAD is entered with the number of stall cycles still to go after this one
    localparam logic [1:0] WAIT_INIT = (LOAD_WAIT > 0) ? 2'(LOAD_WAIT - 1) : 2'd0;

    state_t           state, state_nxt;
    logic [1:0]       wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0] count_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            wait_cnt    <= 2'd0;
            INSTR_COUNT <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            INSTR_COUNT <= count_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        wait_cnt_nxt       = wait_cnt;
        count_nxt          = INSTR_COUNT;
        DP_INIT            = 1'b0;
        PC_HOLD            = 1'b1;
        CTRL_branch_rel_nz = 1'b0;
        CTRL_branch_rel_z  = 1'b0;
        CTRL_branch_abs    = 1'b0;
        CTRL_reg_write_en  = 1'b0;
        CTRL_reg_sel       = 1'b0;
        CTRL_lut_in        = 1'b0;
        CTRL_mem_to_reg    = 1'b0;
        CTRL_alu_src       = 1'b0;
        CTRL_alu_sc_in     = 1'b0;
        CTRL_read_mem      = 1'b0;
        CTRL_write_mem     = 1'b0;
        CTRL_alu_op        = 3'd0;

        case (state)
            S_IDLE, S_HALTED: begin
                if (START) begin
                    state_nxt = S_INIT;
                    count_nxt = '0;
                end
            end

            S_INIT: begin
                DP_INIT   = 1'b1;
                PC_HOLD   = 1'b0;
                count_nxt = '0;
                state_nxt = S_RUN;
            end

            S_RUN: begin
                // End-of-program flag squashes whatever is being decoded
                if (DONE) begin
                    state_nxt = S_HALTED;
                end else begin
                    PC_HOLD   = 1'b0;
                    count_nxt = sat_inc(INSTR_COUNT);
                    case (opcode)
                        4'h0: CTRL_reg_write_en = 1'b1;
                        4'h1: begin CTRL_reg_write_en = 1'b1; CTRL_alu_op = 3'd1; end
                        4'h2: begin CTRL_reg_write_en = 1'b1; CTRL_alu_op = 3'd2; end
                        4'h3: begin CTRL_reg_write_en = 1'b1; CTRL_alu_op = 3'd3; end
                        4'h4: begin CTRL_reg_write_en = 1'b1; CTRL_alu_op = 3'd4; end
                        4'h5: begin
                            CTRL_reg_write_en = 1'b1;
                            CTRL_alu_op       = 3'd5;
                            CTRL_alu_sc_in    = fcode;
                        end
                        4'h6: begin
                            CTRL_reg_write_en = 1'b1;
                            CTRL_alu_op       = 3'd6;
                            CTRL_alu_sc_in    = fcode;
                        end
                        4'h7: begin CTRL_reg_write_en = 1'b1; CTRL_alu_src = 1'b1; end
                        4'h8: begin
                            CTRL_read_mem   = 1'b1;
                            CTRL_mem_to_reg = 1'b1;
                            if (LOAD_WAIT > 0) begin
                                PC_HOLD      = 1'b1;
                                count_nxt    = INSTR_COUNT;
                                wait_cnt_nxt = WAIT_INIT;
                                state_nxt    = S_LOAD;
                            end else begin
                                CTRL_reg_write_en = 1'b1;
                            end
                        end
                        4'h9: CTRL_write_mem = 1'b1;
                        4'hA: CTRL_branch_rel_nz = 1'b1;
                        4'hB: CTRL_branch_rel_z = 1'b1;
                        4'hC: CTRL_branch_abs = 1'b1;
                        4'hD: begin CTRL_reg_sel = 1'b1; CTRL_reg_write_en = 1'b1; end
                        4'hE: begin CTRL_branch_abs = 1'b1; CTRL_lut_in = 1'b1; end
                        default: begin
                            if (fcode) state_nxt = S_HALTED;
                        end
                    endcase
                end
            end

            S_LOAD: begin
                if (DONE) begin
                    state_nxt = S_HALTED;
                end else begin
                    CTRL_read_mem   = 1'b1;
                    CTRL_mem_to_reg = 1'b1;
                    // Final stall cycle writes back and releases the PC
                    if (wait_cnt == 2'd0) begin
                        CTRL_reg_write_en = 1'b1;
                        PC_HOLD           = 1'b0;
                        count_nxt         = sat_inc(INSTR_COUNT);
                        state_nxt         = S_RUN;
                    end else begin
                        wait_cnt_nxt = wait_cnt - 2'd1;
                    end
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    assign BUSY     = (state == S_INIT) || (state == S_RUN) || (state == S_LOAD);
    assign FINISHED = (state == S_HALTED);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: two instances (LOAD_WAIT=2/CNT_W=16 and
// LOAD_WAIT=0/CNT_W=3) checked against a behavioural model, a decode table and corner sequences.
module tb_ctrl_sequencer;

    localparam int B_DPI = 15, B_HOLD = 14, B_BNZ = 13, B_BZ = 12, B_BABS = 11;
    localparam int B_WR = 10, B_RSEL = 9, B_LUT = 8, B_M2R = 7, B_SRC = 6;
    localparam int B_SC = 5, B_RD = 4, B_WM = 3;
    localparam int P_IDLE = 0, P_INIT = 1, P_RUN = 2, P_LOAD = 3, P_HALT = 4;

    logic        CLK, RESET_N, START, fcode, DONE;
    logic [3:0]  opcode;
    logic [15:0] va, vb;
    logic        busy_a, busy_b, fin_a, fin_b;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    int ph[2], left[2], mcnt[2];
    int lw_p[2] = '{2, 0};
    int cmax[2] = '{65535, 7};

    ctrl_sequencer #(.LOAD_WAIT(2), .CNT_W(16)) dut_a (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .opcode(opcode), .fcode(fcode),
        .DONE(DONE), .DP_INIT(va[15]), .PC_HOLD(va[14]),
        .CTRL_branch_rel_nz(va[13]), .CTRL_branch_rel_z(va[12]), .CTRL_branch_abs(va[11]),
        .CTRL_reg_write_en(va[10]), .CTRL_reg_sel(va[9]), .CTRL_lut_in(va[8]),
        .CTRL_mem_to_reg(va[7]), .CTRL_alu_src(va[6]), .CTRL_alu_sc_in(va[5]),
        .CTRL_read_mem(va[4]), .CTRL_write_mem(va[3]), .CTRL_alu_op(va[2:0]),
        .BUSY(busy_a), .FINISHED(fin_a), .INSTR_COUNT(cnt_a)
    );

    ctrl_sequencer #(.LOAD_WAIT(0), .CNT_W(3)) dut_b (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .opcode(opcode), .fcode(fcode),
        .DONE(DONE), .DP_INIT(vb[15]), .PC_HOLD(vb[14]),
        .CTRL_branch_rel_nz(vb[13]), .CTRL_branch_rel_z(vb[12]), .CTRL_branch_abs(vb[11]),
        .CTRL_reg_write_en(vb[10]), .CTRL_reg_sel(vb[9]), .CTRL_lut_in(vb[8]),
        .CTRL_mem_to_reg(vb[7]), .CTRL_alu_src(vb[6]), .CTRL_alu_sc_in(vb[5]),
        .CTRL_read_mem(vb[4]), .CTRL_write_mem(vb[3]), .CTRL_alu_op(vb[2:0]),
        .BUSY(busy_b), .FINISHED(fin_b), .INSTR_COUNT(cnt_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Strobe set of an instruction, straight from the ISA table
    function automatic logic [13:0] spec_decode(input logic [3:0] op, input logic fc);
        logic [13:0] s;
        s = '0;
        if (op <= 4'd6) begin
            s[B_WR]  = 1'b1;
            s[2:0]   = op[2:0];
            s[B_SC]  = (op == 4'd5 || op == 4'd6) ? fc : 1'b0;
        end else if (op == 4'd7) begin
            s[B_WR] = 1'b1; s[B_SRC] = 1'b1;
        end else if (op == 4'd8) begin
            s[B_RD] = 1'b1; s[B_M2R] = 1'b1; s[B_WR] = 1'b1;
        end else if (op == 4'd9)  s[B_WM] = 1'b1;
        else if (op == 4'd10) s[B_BNZ] = 1'b1;
        else if (op == 4'd11) s[B_BZ] = 1'b1;
        else if (op == 4'd12) s[B_BABS] = 1'b1;
        else if (op == 4'd13) begin s[B_RSEL] = 1'b1; s[B_WR] = 1'b1; end
        else if (op == 4'd14) begin s[B_BABS] = 1'b1; s[B_LUT] = 1'b1; end
        return s;
    endfunction

    function automatic logic [15:0] model_out(input int k);
        logic [15:0] v;
        logic [13:0] s;
        v = '0;
        if (ph[k] == P_IDLE || ph[k] == P_HALT) v[B_HOLD] = 1'b1;
        else if (ph[k] == P_INIT) v[B_DPI] = 1'b1;
        else if (DONE) v[B_HOLD] = 1'b1;
        else if (ph[k] == P_RUN) begin
            s = spec_decode(opcode, fcode);
            if (opcode == 4'd8 && lw_p[k] > 0) begin
                s[B_WR] = 1'b0; v[B_HOLD] = 1'b1;
            end
            v[13:0] = s;
        end else begin
            v[B_RD] = 1'b1; v[B_M2R] = 1'b1;
            if (left[k] == 1) v[B_WR] = 1'b1;
            else v[B_HOLD] = 1'b1;
        end
        return v;
    endfunction

    function automatic int sat(input int k, input int c);
        return (c < cmax[k]) ? c + 1 : c;
    endfunction

    task automatic model_step(input int k);
        case (ph[k])
            P_IDLE, P_HALT: if (START) begin ph[k] = P_INIT; mcnt[k] = 0; end
            P_INIT: begin ph[k] = P_RUN; mcnt[k] = 0; end
            P_RUN: begin
                if (DONE) ph[k] = P_HALT;
                else if (opcode == 4'd8 && lw_p[k] > 0) begin
                    ph[k] = P_LOAD; left[k] = lw_p[k];
                end else begin
                    mcnt[k] = sat(k, mcnt[k]);
                    if (opcode == 4'hF && fcode) ph[k] = P_HALT;
                end
            end
            default: begin
                if (DONE) ph[k] = P_HALT;
                else if (left[k] == 1) begin mcnt[k] = sat(k, mcnt[k]); ph[k] = P_RUN; end
                else left[k] = left[k] - 1;
            end
        endcase
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin ph[k] = P_IDLE; left[k] = 0; mcnt[k] = 0; end
    endtask

    task automatic check_model();
        chk("a_outputs", int'(va), int'(model_out(0)));
        chk("b_outputs", int'(vb), int'(model_out(1)));
        chk("a_busy", int'(busy_a), int'(ph[0] == P_INIT || ph[0] == P_RUN || ph[0] == P_LOAD));
        chk("b_busy", int'(busy_b), int'(ph[1] == P_INIT || ph[1] == P_RUN || ph[1] == P_LOAD));
        chk("a_finished", int'(fin_a), int'(ph[0] == P_HALT));
        chk("b_finished", int'(fin_b), int'(ph[1] == P_HALT));
        chk("a_count", int'(cnt_a), mcnt[0]);
        chk("b_count", int'(cnt_b), mcnt[1]);
    endtask

    task automatic drive(input logic [3:0] op, input logic fc, input logic dn, input logic st);
        opcode = op; fcode = fc; DONE = dn; START = st;
        #2;
        check_model();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic reset_mid();
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rst_a_outputs", int'(va), 32'h4000);
        chk("rst_b_outputs", int'(vb), 32'h4000);
        chk("rst_busy", int'(busy_a | busy_b), 0);
        chk("rst_finished", int'(fin_a | fin_b), 0);
        chk("rst_a_count", int'(cnt_a), 0);
        chk("rst_b_count", int'(cnt_b), 0);
        model_reset();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        fc;
        logic [13:0] exp_s;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{4'h0, 1'b0, 14'b000_1_000_000_0_000};
        tbl[1]  = '{4'h1, 1'b0, 14'b000_1_000_000_0_001};
        tbl[2]  = '{4'h2, 1'b1, 14'b000_1_000_000_0_010};
        tbl[3]  = '{4'h3, 1'b0, 14'b000_1_000_000_0_011};
        tbl[4]  = '{4'h4, 1'b0, 14'b000_1_000_000_0_100};
        tbl[5]  = '{4'h5, 1'b1, 14'b000_1_000_010_0_101};
        tbl[6]  = '{4'h5, 1'b0, 14'b000_1_000_000_0_101};
        tbl[7]  = '{4'h6, 1'b1, 14'b000_1_000_010_0_110};
        tbl[8]  = '{4'h7, 1'b0, 14'b000_1_000_100_0_000};
        tbl[9]  = '{4'h9, 1'b0, 14'b000_0_000_000_1_000};
        tbl[10] = '{4'hA, 1'b0, 14'b100_0_000_000_0_000};
        tbl[11] = '{4'hB, 1'b0, 14'b010_0_000_000_0_000};
        tbl[12] = '{4'hC, 1'b0, 14'b001_0_000_000_0_000};
        tbl[13] = '{4'hD, 1'b0, 14'b000_1_100_000_0_000};
        tbl[14] = '{4'hE, 1'b0, 14'b001_0_010_000_0_000};
        tbl[15] = '{4'hF, 1'b0, 14'b000_0_000_000_0_000};

        RESET_N = 1'b0; START = 1'b0; DONE = 1'b0; opcode = 4'h0; fcode = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        chk("por_outputs", int'(va), 32'h4000);
        chk("por_count", int'(cnt_a), 0);
        RESET_N = 1'b1;

        // START pulse: one-cycle DP_INIT, then RUN
        drive(4'hF, 1'b0, 1'b0, 1'b1);
        chk("idle_no_init", int'(va[B_DPI]), 0);
        tick();
        drive(4'hF, 1'b0, 1'b0, 1'b0);
        chk("init_pulse", int'(va[B_DPI]), 1);
        chk("init_pc_free", int'(va[B_HOLD]), 0);
        tick();
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        chk("run_pulse_gone", int'(va[B_DPI]), 0);
        chk("run_busy", int'(busy_a), 1);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].op, tbl[i].fc, 1'b0, 1'b0);
            chk($sformatf("tbl_a_op%0h_f%0d", tbl[i].op, tbl[i].fc), int'(va[13:0]), int'(tbl[i].exp_s));
            chk($sformatf("tbl_b_op%0h_f%0d", tbl[i].op, tbl[i].fc), int'(vb[13:0]), int'(tbl[i].exp_s));
            chk("tbl_pc_free", int'(va[B_HOLD]), 0);
            tick();
        end
        chk("tbl_a_count", int'(cnt_a), 16);
        chk("tbl_b_count_sat", int'(cnt_b), 7);

        // LW with LOAD_WAIT=2 on dut_a, single-cycle LW on dut_b
        drive(4'h8, 1'b0, 1'b0, 1'b0);
        chk("lw1_hold", int'(va[B_HOLD]), 1);
        chk("lw1_rd", int'(va[B_RD]), 1);
        chk("lw1_wr", int'(va[B_WR]), 0);
        chk("lw0_b_wr", int'(vb[B_WR]), 1);
        chk("lw0_b_hold", int'(vb[B_HOLD]), 0);
        tick();
        drive(4'h8, 1'b0, 1'b0, 1'b0);
        chk("lw2_hold", int'(va[B_HOLD]), 1);
        chk("lw2_rd", int'(va[B_RD]), 1);
        chk("lw2_wr", int'(va[B_WR]), 0);
        tick();
        drive(4'h8, 1'b0, 1'b0, 1'b0);
        chk("lw3_rd", int'(va[B_RD]), 1);
        chk("lw3_wr", int'(va[B_WR]), 1);
        chk("lw3_hold", int'(va[B_HOLD]), 0);
        tick();
        chk("lw_count", int'(cnt_a), 17);

        drive(4'hF, 1'b1, 1'b0, 1'b0);
        chk("halt_strobes", int'(va[13:0]), 0);
        tick();
        chk("halt_finished", int'(fin_a), 1);
        chk("halt_count", int'(cnt_a), 18);

        // Fresh run: 5 ADDs then HALT
        drive(4'h0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        chk("restart_a_count", int'(cnt_a), 0);
        chk("restart_b_count", int'(cnt_b), 0);
        tick();
        for (int i = 0; i < 5; i++) begin drive(4'h0, 1'b0, 1'b0, 1'b0); tick(); end
        drive(4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        chk("prog_finished", int'(fin_a), 1);
        chk("prog_busy", int'(busy_a), 0);
        chk("prog_a_count", int'(cnt_a), 6);
        chk("prog_b_count", int'(cnt_b), 6);

        // START while busy ignored; DONE beats SW and START
        drive(4'h0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        chk("init2_count", int'(cnt_a), 0);
        tick();
        drive(4'h0, 1'b0, 1'b0, 1'b1);
        chk("busy_start_no_init", int'(va[B_DPI]), 0);
        tick();
        chk("busy_start_still_run", int'(busy_a), 1);
        drive(4'h9, 1'b0, 1'b1, 1'b1);
        chk("done_sw_a", int'(va[B_WM]), 0);
        chk("done_sw_b", int'(vb[B_WM]), 0);
        tick();
        chk("done_finished", int'(fin_a), 1);
        chk("done_count", int'(cnt_a), 1);

        // Reset in the middle of a run
        drive(4'h0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("pre_reset_count", int'(cnt_a), 2);
        reset_mid();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_mid();
            end else begin
                drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 5) == 0));
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
